// File: rtl/vga_sync_if.sv
// rtl/vga_sync_if.sv - raster timing bundle from vga_sync to its consumers
//
// Signals:
//   x, y        current pixel coordinates (11 bits each)
//   hsync       horizontal sync pin level
//   vsync       vertical sync pin level
//   video_on    high while (x, y) lies in the visible area
//   pix_tick    one-clock strobe; coordinates advance on the following edge
//   frame_tick  one-clock strobe on the frame wrap edge
// Modports: master (generator side, drives everything), slave (consumer side).

interface vga_sync_if;
    logic [10:0] x;
    logic [10:0] y;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        pix_tick;
    logic        frame_tick;

    modport master (
        output x, y, hsync, vsync, video_on, pix_tick, frame_tick
    );

    modport slave (
        input x, y, hsync, vsync, video_on, pix_tick, frame_tick
    );
endinterface

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - 640x480@60 VGA raster timing generator
//
// Ports:
//   clk    system clock, the only clock
//   reset  synchronous, active-high reset
//   bus    vga_sync_if.master: x, y, hsync, vsync, video_on, pix_tick, frame_tick
//
// Optional feature macro: VGA_SYNC_FRAME_TICK_EN
//   defined   -> frame_tick is a registered one-clock pulse on the (last,last)->(0,0) edge
//   undefined -> frame_tick is tied to 0 and no frame-detect logic exists

module vga_sync #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    // A one-bit divider is kept even for CLK_DIV = 1; it then never leaves 0,
    // which matches DIV_LAST and holds pix_tick at 1.
    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [10:0]      x_q;
    logic [10:0]      y_q;
    logic [10:0]      x_nxt;
    logic [10:0]      y_nxt;
    logic             hsync_q;
    logic             vsync_q;
    logic             video_on_q;
    logic             pix_tick;

    assign pix_tick = (div == DIV_LAST);

    always_comb begin
        div_nxt = div;
        x_nxt   = x_q;
        y_nxt   = y_q;
        if (pix_tick) begin
            div_nxt = '0;
            if (x_q == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_nxt = x_q + 11'd1;
            end
        end else begin
            div_nxt = div + DIV_W'(1);
        end
    end

    // Sync/blank flags are decoded from the next-state coordinates so that,
    // once registered, they line up with the x/y they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            div        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            video_on_q <= 1'b1;
        end else begin
            div        <= div_nxt;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            hsync_q    <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vsync_q    <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            video_on_q <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
        end
    end

`ifdef VGA_SYNC_FRAME_TICK_EN
    logic frame_tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= pix_tick && (x_q == H_LAST) && (y_q == V_LAST);
        end
    end

    assign bus.frame_tick = frame_tick_q;
`else
    assign bus.frame_tick = 1'b0;
`endif

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.hsync    = hsync_q;
    assign bus.vsync    = vsync_q;
    assign bus.video_on = video_on_q;
    assign bus.pix_tick = pix_tick;

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - self-checking bench for vga_sync (three parameter sets)

module tb_vga_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vga_sync_if bus_a ();
    vga_sync_if bus_s ();
    vga_sync_if bus_c ();

    // Default timing.
    vga_sync dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    // Miniature raster so whole frames fit in a short run: 15 x 10, div 2.
    vga_sync #(
        .CLK_DIV (2), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1), .SYNC_POL (1'b0)
    ) dut_s (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_s)
    );

    // Undivided clock, active-high sync.
    vga_sync #(
        .CLK_DIV (1), .SYNC_POL (1'b1)
    ) dut_c (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_c)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: clocks since reset -> pixel index -> coordinates -> flags.
    int  c     = 0;
    bit  valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            c     <= 0;
            valid <= 1'b1;
        end else begin
            c <= c + 1;
        end
    end

    task automatic check_inst(
        input string nm, input int cc,
        input int d, input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp, input bit pol,
        input logic [10:0] ax, input logic [10:0] ay, input logic ahs, input logic avs,
        input logic avo, input logic apt, input logic aft
    );
        int  ht, vt, n, ex, ey;
        bit  ehs, evs, evo, ept, eft;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        n   = cc / d;
        ex  = n % ht;
        ey  = (n / ht) % vt;
        ehs = (ex >= ha + hfp && ex < ha + hfp + hsw) ? pol : !pol;
        evs = (ey >= va + vfp && ey < va + vfp + vsw) ? pol : !pol;
        evo = (ex < ha) && (ey < va);
        ept = (cc % d) == d - 1;
`ifdef VGA_SYNC_FRAME_TICK_EN
        eft = (n > 0) && (n % (ht * vt) == 0) && (cc % d == 0);
`else
        eft = 1'b0;
`endif
        chk({nm, ".x"},          32'(ax),  32'(ex));
        chk({nm, ".y"},          32'(ay),  32'(ey));
        chk({nm, ".hsync"},      32'(ahs), 32'(ehs));
        chk({nm, ".vsync"},      32'(avs), 32'(evs));
        chk({nm, ".video_on"},   32'(avo), 32'(evo));
        chk({nm, ".pix_tick"},   32'(apt), 32'(ept));
        chk({nm, ".frame_tick"}, 32'(aft), 32'(eft));
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check_inst("a", c, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                       bus_a.x, bus_a.y, bus_a.hsync, bus_a.vsync,
                       bus_a.video_on, bus_a.pix_tick, bus_a.frame_tick);
            check_inst("s", c, 2, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0,
                       bus_s.x, bus_s.y, bus_s.hsync, bus_s.vsync,
                       bus_s.video_on, bus_s.pix_tick, bus_s.frame_tick);
            check_inst("c", c, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1,
                       bus_c.x, bus_c.y, bus_c.hsync, bus_c.vsync,
                       bus_c.video_on, bus_c.pix_tick, bus_c.frame_tick);
        end
    end

    // Hand-computed expectations, sampled 1 time unit after the k-th edge
    // following reset release.
    task automatic literal_checks(input int k);
        case (k)
            1: chk("lit.a.x_k1", 32'(bus_a.x), 32'd0);
            2: chk("lit.a.x_k2", 32'(bus_a.x), 32'd1);
            210: chk("lit.s.vsync_y7", 32'(bus_s.vsync), 32'd0);
            298: begin
                chk("lit.s.x_k298", 32'(bus_s.x), 32'd14);
                chk("lit.s.y_k298", 32'(bus_s.y), 32'd9);
            end
            300: begin
                chk("lit.s.x_wrap", 32'(bus_s.x), 32'd0);
                chk("lit.s.y_wrap", 32'(bus_s.y), 32'd0);
`ifdef VGA_SYNC_FRAME_TICK_EN
                chk("lit.s.frame_tick", 32'(bus_s.frame_tick), 32'd1);
`else
                chk("lit.s.frame_tick", 32'(bus_s.frame_tick), 32'd0);
`endif
            end
            655: chk("lit.c.hsync_655", 32'(bus_c.hsync), 32'd0);
            656: begin
                chk("lit.c.x_656", 32'(bus_c.x), 32'd656);
                chk("lit.c.hsync_656", 32'(bus_c.hsync), 32'd1);
            end
            752: chk("lit.c.hsync_752", 32'(bus_c.hsync), 32'd0);
            1280: begin
                chk("lit.a.x_640", 32'(bus_a.x), 32'd640);
                chk("lit.a.video_on_640", 32'(bus_a.video_on), 32'd0);
            end
            1311: chk("lit.a.hsync_655", 32'(bus_a.hsync), 32'd1);
            1312: chk("lit.a.hsync_656", 32'(bus_a.hsync), 32'd0);
            1503: chk("lit.a.hsync_751", 32'(bus_a.hsync), 32'd0);
            1504: chk("lit.a.hsync_752", 32'(bus_a.hsync), 32'd1);
            1599: chk("lit.a.x_799", 32'(bus_a.x), 32'd799);
            1600: begin
                chk("lit.a.x_line", 32'(bus_a.x), 32'd0);
                chk("lit.a.y_line", 32'(bus_a.y), 32'd1);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lit.a.reset_x", 32'(bus_a.x), 32'd0);
        chk("lit.a.reset_y", 32'(bus_a.y), 32'd0);
        chk("lit.a.reset_hsync", 32'(bus_a.hsync), 32'd1);
        chk("lit.a.reset_vsync", 32'(bus_a.vsync), 32'd1);
        chk("lit.a.reset_video_on", 32'(bus_a.video_on), 32'd1);
        rst = 1'b0;

        for (int k = 1; k <= 1700; k++) begin
            @(posedge clk);
            #1;
            literal_checks(k);
        end

        // One-cycle reset in the middle of a frame.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("lit.mid.a_x", 32'(bus_a.x), 32'd0);
        chk("lit.mid.a_y", 32'(bus_a.y), 32'd0);
        chk("lit.mid.s_x", 32'(bus_s.x), 32'd0);
        chk("lit.mid.s_hsync", 32'(bus_s.hsync), 32'd1);
        chk("lit.mid.c_hsync", 32'(bus_c.hsync), 32'd0);
        rst = 1'b0;

        for (int k = 1; k <= 700; k++) begin
            @(posedge clk);
            #1;
            literal_checks(k);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Generates 640x480 @ 60 Hz VGA raster timing: a pixel-rate enable, the current pixel coordinates `x`/`y`, and the `hsync`/`vsync`/`video_on` signals. It produces the coordinate stream that the graphics pipeline (`graphic`) consumes to decide each pixel's colour, and it drives the board's sync pins. All outputs change together on pixel-enable cycles, so downstream logic sees a coherent (x, y, sync) tuple.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync` (0 = active-low).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `x`  out  11  horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800).
- `y`  out  11  vertical count, 0..V_TOTAL-1 (V_TOTAL = 525).
- `hsync`  out  1  horizontal sync at level SYNC_POL while asserted.
- `vsync`  out  1  vertical sync at level SYNC_POL while asserted.
- `video_on`  out  1  high iff x < H_ACTIVE and y < V_ACTIVE.
- `pix_tick`  out  1  one-clock strobe; the coordinates advance on the following edge.
- `frame_tick`  out  1  one-clock strobe at frame wrap (see Configuration).

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pix_tick` = (div == CLK_DIV-1), decoded combinationally. With CLK_DIV = 1, `pix_tick` is held at 1.
- On a clock edge where `pix_tick` = 1:
  - If x == H_TOTAL-1, x wraps to 0 and y advances; otherwise x increments.
  - If y is already V_TOTAL-1 when x wraps, y also wraps to 0.
- Counters hold on edges where `pix_tick` = 0.
- Sync and blank regions:
  - `hsync` is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751 by default.
  - `vsync` is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 490..491 by default.
- `hsync`, `vsync` and `video_on` are registers. They are computed from the next-state counter values, so they are valid on the same cycle as the `x`/`y` they describe.
- x and y keep counting through blanking. Consumers gate on `video_on`.
- All widths are 11 bits unsigned. Derived totals are computed at elaboration time and must fit 11 bits.

## Timing
- Reset values: div = 0, x = 0, y = 0, `video_on` = 1, `hsync` = `vsync` = ~SYNC_POL (deasserted), `frame_tick` = 0.
- Reset mid-frame: on the next edge all registers take their reset values, whatever the prior state. The first `pix_tick` after release occurs CLK_DIV-1 cycles later.
- Latency:
  - x/y change exactly one edge after a `pix_tick` cycle.
  - `hsync`/`vsync`/`video_on` change on that same edge.
- Line period: H_TOTAL × CLK_DIV clocks (1600 by default).
- Frame period: H_TOTAL × V_TOTAL × CLK_DIV clocks (840000 by default).
- Simultaneous x wrap and y wrap: both counters become 0 on the same edge.
- Simultaneous `reset` and `pix_tick`: reset wins.

## Configuration
- `VGA_SYNC_FRAME_TICK_EN`
- Defined:
  - `frame_tick` is a register, high for exactly one clock.
  - It asserts on the edge where (x, y) goes from (H_TOTAL-1, V_TOTAL-1) to (0, 0).
  - Game logic uses it to update sprites once per frame.
- Undefined:
  - `frame_tick` is tied to 0 and no frame-detect logic is synthesized.
  - The port remains present.

## Test plan
- Reset, default params: x=0, y=0, `video_on`=1, `hsync`=1, `vsync`=1. The first x=1 appears 2 clocks after reset release.
- Run one line: x reaches 799 and then 0 with y=1 after 1600 clocks. `hsync`=0 exactly for x 656..751; `video_on`=0 for x 640..799.
- Run one frame: `vsync`=0 only for y 490..491. (799,524) -> (0,0); with `VGA_SYNC_FRAME_TICK_EN`, `frame_tick` pulses once per 840000 clocks.
- Assert reset for one cycle at x=300, y=200 → next cycle x=0, y=0, sync deasserted. Timing then restarts identically to a fresh reset.
- CLK_DIV=1, SYNC_POL=1: x advances every clock, `pix_tick` is constantly 1, and `hsync`=1 only for x 656..751.
- Without `VGA_SYNC_FRAME_TICK_EN`: `frame_tick` stays 0 across two full frames.
